// File: rtl/rr_grant_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler_if
// Description : Request/grant bundle between four requesters and the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_grant_scheduler_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Four-way round-robin scheduler with bounded hold time.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rr_grant_scheduler_if.slave bus
);

    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_grant = 1'b1;
    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [0:0]       state_q,    state_d;
    logic [1:0]       owner_q,    owner_d;
    logic [1:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             preempt_q,  preempt_d;
    logic [3:0]       w_others;

    // First set bit of r searching circularly from start; lowest offset wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign w_others = bus.req & ~(4'b0001 << owner_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (|bus.req) begin
                    owner_d    = pick(bus.req, ptr_q);
                    hold_cnt_d = c_cnt_one;
                    state_d    = c_st_grant;
                end
            end
            default: begin
                if (!bus.req[owner_q]) begin
                    ptr_d = owner_q + 2'd1;
                    if (|bus.req) begin
                        owner_d    = pick(bus.req, owner_q + 2'd1);
                        hold_cnt_d = c_cnt_one;
                    end else begin
                        owner_d    = 2'd0;
                        hold_cnt_d = '0;
                        state_d    = c_st_idle;
                    end
                end else if (hold_cnt_q == c_max_hold) begin
                    // Old owner is masked out, so a preemption always moves the grant.
                    if (|w_others) begin
                        owner_d    = pick(w_others, owner_q + 2'd1);
                        ptr_d      = owner_q + 2'd1;
                        hold_cnt_d = c_cnt_one;
                        preempt_d  = 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + c_cnt_one;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_st_idle;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    // Outputs decode from flops only, so grant is one-hot by construction.
    assign bus.grant       = (state_q == c_st_grant) ? (4'b0001 << owner_q) : 4'b0000;
    assign bus.grant_idx   = (state_q == c_st_grant) ? owner_q : 2'd0;
    assign bus.grant_valid = (state_q == c_st_grant);
    assign bus.preempt     = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_scheduler
// Description : Directed-vector bench for rr_grant_scheduler (MAX_HOLD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    rr_grant_scheduler_if bus();

    rr_grant_scheduler #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected {grant, grant_idx, grant_valid, preempt} from a hand-written grant.
    function automatic logic [7:0] pack_exp(input logic [3:0] g, input logic p);
        logic [1:0] idx;
        case (g)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return {g, idx, |g, p};
    endfunction

    task automatic step_check(input string tag, input logic [3:0] g, input logic p);
        @(posedge clk);
        #1;
        chk(tag, {24'd0, bus.grant, bus.grant_idx, bus.grant_valid, bus.preempt},
            {24'd0, pack_exp(g, p)});
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = 4'b1111;

        for (int i = 0; i < 3; i++) step_check($sformatf("rst_%0d", i), 4'b0000, 1'b0);
        reset = 1'b0;

        // Full contention: each owner holds 8 cycles, preempt on each handover.
        for (int o = 0; o < 4; o++)
            for (int c = 0; c < 8; c++)
                step_check($sformatf("rot%0d_%0d", o, c), 4'(4'b0001 << o),
                           (c == 0) && (o != 0));
        step_check("rot_wrap", 4'b0001, 1'b1);

        // Release handoffs, no bubble.
        bus.req = 4'b1000;
        step_check("rel_0to3", 4'b1000, 1'b0);
        bus.req = 4'b0011;
        step_check("rel_3to0", 4'b0001, 1'b0);
        bus.req = 4'b0010;
        step_check("rel_0to1", 4'b0010, 1'b0);

        // Drop to idle, then a fresh request.
        bus.req = 4'b0000;
        step_check("idle", 4'b0000, 1'b0);
        step_check("idle_hold", 4'b0000, 1'b0);
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) step_check($sformatf("solo2_%0d", i), 4'b0100, 1'b0);

        // Saturated counter must preempt as soon as contention appears.
        bus.req = 4'b1111;
        step_check("sat_preempt", 4'b1000, 1'b1);
        step_check("post_preempt", 4'b1000, 1'b0);
        bus.req = 4'b0100;
        step_check("rel_3to2", 4'b0100, 1'b0);

        // Reset mid-grant wins over contention; ptr back to 0.
        bus.req = 4'b1111;
        reset   = 1'b1;
        step_check("rst_mid", 4'b0000, 1'b0);
        reset   = 1'b0;
        step_check("post_rst", 4'b0001, 1'b0);
        bus.req = 4'b0000;
        step_check("final_idle", 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
Round-robin scheduler that shares one resource among four requesters.
- Outputs a registered one-hot grant vector plus its 2-bit encoded index, using the 0001→00, 0010→01, 0100→10, 1000→11 mapping.
- The grant vector is guaranteed legal one-hot (or all-zero), so downstream encoding never sees an error input.
- Enforces a bounded hold time so a requester that stays asserted cannot starve the others.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles for one owner while another requester is waiting; legal range 1..15.
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock; all logic updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req  input  4  request lines; req[i] high means requester i wants the resource.
grant  output  4  one-hot grant, registered; 0000 when no owner.
grant_idx  output  2  encoded index of the current owner, registered; 00 when grant_valid=0.
grant_valid  output  1  high while grant is non-zero.
preempt  output  1  one-cycle pulse in the first cycle of a grant that was taken away from an owner that was still requesting.

Behaviour:
Internal state:
- State register: IDLE, GRANT.
- ptr[1:0]: highest-priority requester for the next arbitration.
- owner[1:0].
- hold_cnt[CNT_W-1:0].

Reset (synchronous, overrides all else, including mid-grant):
- grant=0000, grant_idx=00, grant_valid=0, preempt=0.
- ptr=0, hold_cnt=0, state=IDLE.

Arbitration function pick(start):
- Returns the first i with req[i]=1, searching circularly start, start+1, ... modulo 4.

IDLE:
- If req==0000: stay in IDLE, outputs stay zero.
- Else at the edge: owner=pick(ptr), grant=onehot(owner), grant_idx=owner, grant_valid=1, hold_cnt=1, preempt=0, state=GRANT.
- Latency: req sampled at edge k appears as grant after edge k (one cycle, no combinational path from req to grant).

GRANT, evaluated each edge with priority top-down:
1. Release (req[owner]=0):
   - ptr=owner+1 (mod 4).
   - If any other req is high: owner=pick(owner+1), hold_cnt=1, preempt=0, stay in GRANT. This is a back-to-back handoff with no idle cycle.
   - Else: grant=0000, grant_idx=00, grant_valid=0, state=IDLE.
2. Preemption (req[owner]=1, hold_cnt==MAX_HOLD, and any req[j]=1 with j!=owner):
   - owner=pick(owner+1) (never the old owner), ptr=old owner+1.
   - hold_cnt=1, preempt=1 for exactly one cycle.
3. Uncontended expiry (req[owner]=1, hold_cnt==MAX_HOLD, no other req):
   - Keep the grant; hold_cnt saturates at MAX_HOLD; preempt=0.
4. Otherwise:
   - Keep the grant; hold_cnt=hold_cnt+1; preempt=0.

Invariants:
- grant has at most one bit set.
- grant_idx always equals the encoding of grant.
- grant_valid == (grant != 0).
- preempt is never high on two consecutive cycles unless MAX_HOLD=1.
- Non-owner req changes mid-grant have no effect until a release or preemption point.
- Requests that assert and drop within the same cycle as an arbitration are simply sampled; there is no request latching.
- With req continuously 1111, each owner holds exactly MAX_HOLD cycles, rotating 0→1→2→3→0.

Test Plan:
1. reset=1 for 3 cycles with req=1111, then release → grant=0000 throughout reset; first edge after release gives grant=0001, grant_idx=00, grant_valid=1.
2. MAX_HOLD=8, only req[2] high for 20 cycles → grant=0100 and grant_idx=10 every cycle after the first; preempt never asserted; hold_cnt saturates at 8.
3. MAX_HOLD=8, req=1111 held → grant 0001 (8 cycles), 0010 (8), 0100 (8), 1000 (8), then 0001 again; preempt=1 only in the first cycle of each of the last four grants.
4. Owner 0 drops req[0] while req=1000 → next edge grant=1000, grant_idx=11, preempt=0, no bubble. After req[3] drops with req=0011 → next grant is 0001, because ptr=0 after owner 3 is released.
5. Owner 1 holding, req drops to 0000 → next edge grant=0000, grant_idx=00, grant_valid=0. Then req=0100 → grant=0100 one edge later.
6. reset pulsed for one cycle while grant=0100 with req=1111 → next edge all outputs zero and ptr=0; first grant after reset is 0001.
